imem_fetch_arbiter: RTL
=======================

IMEM_FETCH_ARBITER -- requirements
Module: imem_fetch_arbiter

Interface
REQ-001 SHALL have parameter LOAD_PRIO, default 0: 0 selects round-robin arbitration, 1 makes the loader always win.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk, in, 1, sole clock, all state on rising edge.
REQ-003 rst, in, 1, asynchronous active-high reset.
REQ-004 fetch_req_valid / fetch_req_ready, in / out, 1 each, fetch request handshake.
REQ-005 fetch_addr, in, 12, byte address of the 32-bit instruction word.
REQ-006 fetch_rsp_valid / fetch_rsp_ready, out / in, 1 each, fetch response handshake.
REQ-007 fetch_rsp_data, out, 32, little-endian word (byte at addr in [7:0]).
REQ-008 fetch_rsp_err, out, 1, misaligned-fetch flag.
REQ-009 load_req_valid / load_req_ready, in / out, 1 each, loader write handshake.
REQ-010 load_addr, in, 12, byte address; load_data, in, 32, word to write.
REQ-011 load_done, out, 1, one-cycle pulse when the write completes.
REQ-012 bram_ena, bram_enb, bram_wea, bram_web, out, 1 each, byte-wide dual-port BRAM controls.
REQ-013 bram_addra, bram_addrb, out, 12; bram_dina, bram_dinb, out, 8; bram_douta, bram_doutb, in, 8, with 1-cycle registered read.

Function
REQ-014 SHALL implement the FSM states IDLE, RD_LO, RD_HI, RD_WAIT, RSP, WR_LO, WR_HI, DONE.
REQ-015 Ready SHALL be asserted only in IDLE, and only to the granted requester; an accept is valid&ready at a rising edge.
REQ-016 Arbitration with LOAD_PRIO=0 SHALL grant the requester not granted last when both are valid; after reset, fetch wins first.
REQ-017 A single valid requester SHALL always be granted.
REQ-018 An accepted fetch SHALL register base={addr[11:2],2'b00} and go to RD_LO.
REQ-019 RD_LO SHALL drive A=base, B=base+1, en=1, we=0.
REQ-020 RD_HI SHALL drive A=base+2, B=base+3, en=1, we=0, and capture douta/doutb into data[7:0]/[15:8].
REQ-021 RD_WAIT SHALL have no enables and SHALL capture douta/doutb into data[23:16]/[31:24].
REQ-022 fetch_rsp_valid SHALL rise exactly 4 cycles after the accept edge and hold with stable data/err until fetch_rsp_ready; then the FSM returns to IDLE.
REQ-023 An accepted load SHALL go to WR_LO, which writes A=base/load_data[7:0] and B=base+1/[15:8] with we=1.
REQ-024 WR_HI SHALL write base+2/[23:16] and base+3/[31:24].
REQ-025 DONE SHALL pulse load_done for 1 cycle, then return to IDLE; load_addr[1:0] is ignored.
REQ-026 bram_en*/we* SHALL be 0 in IDLE, RSP, and DONE; address and data outputs are don't-care when enables are low.
REQ-027 Minimum occupancy SHALL be 5 cycles per fetch and 4 per load; no request is accepted outside IDLE, including the RSP handshake cycle.
REQ-028 Aligned bases SHALL make base+3 at most 0xFFF; no address wrap occurs.

Reset
REQ-029 On rst, outputs SHALL be 0 (fetch_rsp_data=32'h0, all enables 0), FSM=IDLE, and the last-grant flag SHALL point to the loader.
REQ-030 rst mid-operation SHALL abort without a response or load_done; a partially written word stays in the BRAM.

Configuration
REQ-031 With IMEM_MISALIGN_TRAP_EN defined, a fetch with addr[1:0]!=0 SHALL be accepted, skip all BRAM access, and reach RSP next cycle with err=1 and data=32'h0.
REQ-032 Without IMEM_MISALIGN_TRAP_EN, addr[1:0] SHALL be ignored and fetch_rsp_err SHALL be tied 0.

Verification
REQ-033 Preload a BRAM model at 0x000 with 93 00 F0 00, then fetch 0x000 -> rsp_valid 4 cycles after accept, data=0x00F00093, err=0.
REQ-034 Load 0x04C with 0xDEADBEEF, then fetch 0x04C -> load_done pulse, BRAM bytes EF BE AD DE at 0x04C..0x04F, fetch data=0xDEADBEEF.
REQ-035 Hold both requesters valid continuously with LOAD_PRIO=0 -> grants alternate fetch, load, fetch; with LOAD_PRIO=1 -> load always wins.
REQ-036 Hold fetch_rsp_ready low for 3 cycles -> valid and data stable, no BRAM enables, fetch_req_ready=0 throughout.
REQ-037 Fetch 0x002 -> with IMEM_MISALIGN_TRAP_EN, err=1 and data=0 after 2 cycles with no BRAM enable; without it, data equals the word at 0x000.
REQ-038 Assert rst during RD_HI -> all outputs 0 immediately, no response, and a fresh fetch afterwards completes normally.

Source files
------------

// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: shares one byte-wide dual-port BRAM between an
// instruction fetch port (32-bit word reads) and a loader port (32-bit word
// writes). Each word moves as two byte pairs: low half on ports A/B, then the
// high half.
//
// Optional feature: define IMEM_MISALIGN_TRAP_EN to flag fetches whose
// addr[1:0] is nonzero. Such a fetch skips the BRAM and answers err=1 and
// data=0. In the default build addr[1:0] is ignored and fetch_rsp_err is 0.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | arbitrate; ready goes only to the granted requester
// RD_LO   | read bytes base+0/base+1
// RD_HI   | read bytes base+2/base+3; capture the low half of the word
// RD_WAIT | no enables; capture the high half of the word
// RSP     | fetch_rsp_valid held with stable data until fetch_rsp_ready
// WR_LO   | write bytes base+0/base+1 from load_data[15:0]
// WR_HI   | write bytes base+2/base+3 from load_data[31:16]
// DONE    | load_done pulse for one cycle
module imem_fetch_arbiter #(
  parameter int unsigned LOAD_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req_valid,
  output logic        fetch_req_ready,
  input  logic [11:0] fetch_addr,
  output logic        fetch_rsp_valid,
  input  logic        fetch_rsp_ready,
  output logic [31:0] fetch_rsp_data,
  output logic        fetch_rsp_err,
  input  logic        load_req_valid,
  output logic        load_req_ready,
  input  logic [11:0] load_addr,
  input  logic [31:0] load_data,
  output logic        load_done,
  output logic        bram_ena,
  output logic        bram_enb,
  output logic        bram_wea,
  output logic        bram_web,
  output logic [11:0] bram_addra,
  output logic [11:0] bram_addrb,
  output logic [7:0]  bram_dina,
  output logic [7:0]  bram_dinb,
  input  logic [7:0]  bram_douta,
  input  logic [7:0]  bram_doutb
);

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_HI, RD_WAIT, RSP, WR_LO, WR_HI, DONE
  } state_t;

  state_t      state;
  logic        last_load;
  logic [9:0]  word_q;
  logic [15:0] wr_hi_q;
  logic        grant_load;
  logic        misaligned;

  // Byte-offset bits of the load address never matter; addresses are word based.
`ifdef IMEM_MISALIGN_TRAP_EN
  logic        err_q;
  logic [1:0]  unused_addr_bits;
  assign unused_addr_bits = load_addr[1:0];
  assign misaligned       = |fetch_addr[1:0];
  assign fetch_rsp_err    = err_q;
`else
  logic [3:0]  unused_addr_bits;
  assign unused_addr_bits = {fetch_addr[1:0], load_addr[1:0]};
  assign misaligned       = 1'b0;
  assign fetch_rsp_err    = 1'b0;
`endif

  // Arbitration: a lone requester always wins; on a tie the loader wins when
  // LOAD_PRIO is set, otherwise whoever was not granted last.
  always_comb begin
    grant_load = 1'b0;
    if (load_req_valid) begin
      if (!fetch_req_valid)    grant_load = 1'b1;
      else if (LOAD_PRIO != 0) grant_load = 1'b1;
      else                     grant_load = ~last_load;
    end
  end

  // Ready is gated by rst so every output reads 0 while reset is held.
  assign fetch_req_ready = ~rst & (state == IDLE) & fetch_req_valid & ~grant_load;
  assign load_req_ready  = ~rst & (state == IDLE) & grant_load;

  // Sequencer: the state register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      last_load       <= 1'b1;
      word_q          <= 10'h0;
      wr_hi_q         <= 16'h0;
      fetch_rsp_data  <= 32'h0;
      fetch_rsp_valid <= 1'b0;
      load_done       <= 1'b0;
      bram_ena        <= 1'b0;
      bram_enb        <= 1'b0;
      bram_wea        <= 1'b0;
      bram_web        <= 1'b0;
      bram_addra      <= 12'h0;
      bram_addrb      <= 12'h0;
      bram_dina       <= 8'h0;
      bram_dinb       <= 8'h0;
`ifdef IMEM_MISALIGN_TRAP_EN
      err_q           <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (fetch_req_ready) begin
            last_load <= 1'b0;
            word_q    <= fetch_addr[11:2];
`ifdef IMEM_MISALIGN_TRAP_EN
            err_q     <= misaligned;
`endif
            if (misaligned) begin
              state <= RD_WAIT;
            end else begin
              state      <= RD_LO;
              bram_ena   <= 1'b1;
              bram_enb   <= 1'b1;
              bram_wea   <= 1'b0;
              bram_web   <= 1'b0;
              bram_addra <= {fetch_addr[11:2], 2'b00};
              bram_addrb <= {fetch_addr[11:2], 2'b01};
            end
          end else if (load_req_ready) begin
            last_load  <= 1'b1;
            word_q     <= load_addr[11:2];
            wr_hi_q    <= load_data[31:16];
            state      <= WR_LO;
            bram_ena   <= 1'b1;
            bram_enb   <= 1'b1;
            bram_wea   <= 1'b1;
            bram_web   <= 1'b1;
            bram_addra <= {load_addr[11:2], 2'b00};
            bram_addrb <= {load_addr[11:2], 2'b01};
            bram_dina  <= load_data[7:0];
            bram_dinb  <= load_data[15:8];
          end
        end
        RD_LO: begin
          bram_addra <= {word_q, 2'b10};
          bram_addrb <= {word_q, 2'b11};
          state      <= RD_HI;
        end
        RD_HI: begin
          fetch_rsp_data[15:0] <= {bram_doutb, bram_douta};
          bram_ena             <= 1'b0;
          bram_enb             <= 1'b0;
          state                <= RD_WAIT;
        end
        RD_WAIT: begin
`ifdef IMEM_MISALIGN_TRAP_EN
          if (err_q) fetch_rsp_data <= 32'h0;
          else       fetch_rsp_data[31:16] <= {bram_doutb, bram_douta};
`else
          fetch_rsp_data[31:16] <= {bram_doutb, bram_douta};
`endif
          fetch_rsp_valid <= 1'b1;
          state           <= RSP;
        end
        RSP: begin
          if (fetch_rsp_ready) begin
            fetch_rsp_valid <= 1'b0;
            state           <= IDLE;
          end
        end
        WR_LO: begin
          bram_addra <= {word_q, 2'b10};
          bram_addrb <= {word_q, 2'b11};
          bram_dina  <= wr_hi_q[7:0];
          bram_dinb  <= wr_hi_q[15:8];
          state      <= WR_HI;
        end
        WR_HI: begin
          bram_ena  <= 1'b0;
          bram_enb  <= 1'b0;
          bram_wea  <= 1'b0;
          bram_web  <= 1'b0;
          load_done <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          load_done <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
